// File: rtl/alu_sequencer_if.sv
// Request/response bus between a requester and the ALU sequencer.
// The sequencer uses the slave modport and the requester uses the master modport.
interface alu_sequencer_if;
  logic        start;
  logic [4:0]  opcode;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic        done;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic        div_by_zero;
  logic        illegal_op;

  modport master (
    output start, opcode, a, b,
    input  ready, done, result_lo, result_hi, div_by_zero, illegal_op
  );

  modport slave (
    input  start, opcode, a, b,
    output ready, done, result_lo, result_hi, div_by_zero, illegal_op
  );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences one request through an external combinational ALU.
// Flow: latch the operands, drive the ALU, wait the opcode's dwell, then capture the result.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | ready=1, waiting for start
// S_LOAD    | drive alu_y/alu_b/alu_opcode from latched request
// S_EXEC    | wait on down-counter (MUL_CYCLES / DIV_CYCLES / 1)
// S_CAPTURE | register alu_z, or zero results and set the fault flag
// S_DONE    | one-cycle done pulse, then back to S_IDLE
module alu_sequencer #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic               clk,
  input  logic               clr,
  alu_sequencer_if.slave     bus,
  output logic [31:0]        alu_y,
  output logic [31:0]        alu_b,
  output logic [4:0]         alu_opcode,
  input  logic [63:0]        alu_z
);

  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;
  localparam logic [4:0] OP_MAX = 5'b10010;
  localparam logic [7:0] MUL_N  = 8'(MUL_CYCLES);
  localparam logic [7:0] DIV_N  = 8'(DIV_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t      state;
  logic [4:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [7:0]  exec_cnt;
  logic        ready_q;
  logic        done_q;
  logic [31:0] res_lo_q;
  logic [31:0] res_hi_q;
  logic        dbz_q;
  logic        ill_q;

  logic        op_illegal;
  logic        op_div_zero;
  logic [7:0]  exec_len;

  assign op_illegal  = (op_q > OP_MAX);
  assign op_div_zero = (op_q == OP_DIV) && (b_q == 32'd0);
  assign exec_len    = (op_q == OP_MUL) ? MUL_N :
                       (op_q == OP_DIV) ? DIV_N : 8'd1;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= S_IDLE;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      op_q       <= 5'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      exec_cnt   <= 8'd0;
      res_lo_q   <= 32'd0;
      res_hi_q   <= 32'd0;
      dbz_q      <= 1'b0;
      ill_q      <= 1'b0;
      alu_y      <= 32'd0;
      alu_b      <= 32'd0;
      alu_opcode <= 5'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            op_q    <= bus.opcode;
            a_q     <= bus.a;
            b_q     <= bus.b;
            dbz_q   <= 1'b0;
            ill_q   <= 1'b0;
            ready_q <= 1'b0;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          alu_y      <= a_q;
          alu_b      <= b_q;
          alu_opcode <= op_q;
          if (op_illegal || op_div_zero) begin
            state <= S_CAPTURE;
          end else begin
            exec_cnt <= exec_len;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Terminal count at 1 so a dwell of N spends exactly N cycles here.
          if (exec_cnt <= 8'd1) begin
            exec_cnt <= 8'd0;
            state    <= S_CAPTURE;
          end else begin
            exec_cnt <= exec_cnt - 8'd1;
          end
        end
        S_CAPTURE: begin
          if (op_div_zero) begin
            res_lo_q <= 32'd0;
            res_hi_q <= 32'd0;
            dbz_q    <= 1'b1;
          end else if (op_illegal) begin
            res_lo_q <= 32'd0;
            res_hi_q <= 32'd0;
            ill_q    <= 1'b1;
          end else begin
            res_lo_q <= alu_z[31:0];
            res_hi_q <= alu_z[63:32];
          end
          done_q <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ready       = ready_q;
  assign bus.done        = done_q;
  assign bus.result_lo   = res_lo_q;
  assign bus.result_hi   = res_hi_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.illegal_op  = ill_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural ALU plus a latency/result reference model.
module tb_alu_sequencer;
  localparam int MUL_N = 4;
  localparam int DIV_N = 8;

  logic        clk;
  logic        clr;
  logic [31:0] alu_y;
  logic [31:0] alu_b;
  logic [4:0]  alu_opcode;
  logic [63:0] alu_z;

  int tests_run;
  int tests_failed;

  alu_sequencer_if bus ();

  alu_sequencer #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk        (clk),
    .clr        (clr),
    .bus        (bus.slave),
    .alu_y      (alu_y),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_z      (alu_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      5'd3:    alu_fn = 64'(x) + 64'(y);
      5'd15:   alu_fn = 64'(x) * 64'(y);
      5'd16:   alu_fn = (y == 32'd0) ? 64'hDEAD_BEEF_DEAD_BEEF : {x % y, x / y};
      default: alu_fn = {27'd0, op, x ^ y};
    endcase
  endfunction

  always_comb alu_z = alu_fn(alu_opcode, alu_y, alu_b);

  function automatic bit is_skip(input logic [4:0] op, input logic [31:0] y);
    return (op > 5'd18) || (op == 5'd16 && y == 32'd0);
  endfunction

  function automatic int exp_lat(input logic [4:0] op, input logic [31:0] y);
    if (is_skip(op, y)) return 3;
    if (op == 5'd15) return MUL_N + 3;
    if (op == 5'd16) return DIV_N + 3;
    return 4;
  endfunction

  function automatic logic [63:0] exp_res(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    return is_skip(op, x == x ? y : y) ? 64'd0 : alu_fn(op, x, y);
  endfunction

  // Issues one request from a negedge; lat is the cycle (acceptance edge = 0) in which done is seen.
  task automatic do_req(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                        output int lat, output logic [63:0] res, output logic dbz, output logic ill,
                        output logic dbz_load, output logic ill_load, output logic rdy_after,
                        output logic done_after);
    int guard;
    guard = 0;
    while (!bus.ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    bus.start  = 1'b1;
    bus.opcode = op;
    bus.a      = av;
    bus.b      = bv;
    @(negedge clk);
    bus.start = 1'b0;
    lat       = 1;
    dbz_load  = bus.div_by_zero;
    ill_load  = bus.illegal_op;
    while (!bus.done && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    res = {bus.result_hi, bus.result_lo};
    dbz = bus.div_by_zero;
    ill = bus.illegal_op;
    @(negedge clk);
    rdy_after  = bus.ready;
    done_after = bus.done;
  endtask

  task automatic test_reset;
    clr = 1'b1;
    #2 clr = 1'b0;
    #1;
    tests_run++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_handshake: ready=%b done=%b, required ready=1 done=0", bus.ready, bus.done);
    end
    tests_run++;
    if ({bus.result_hi, bus.result_lo, alu_y, alu_b, alu_opcode, bus.div_by_zero, bus.illegal_op} !== '0) begin
      tests_failed++;
      $display("FAIL reset_values: res=%h alu_y=%h alu_b=%h alu_op=%h dbz=%b ill=%b, required all 0",
               {bus.result_hi, bus.result_lo}, alu_y, alu_b, alu_opcode, bus.div_by_zero, bus.illegal_op);
    end
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add;
    int lat; logic [63:0] res; logic dbz, ill, dl, il, ra, da;
    do_req(5'd3, 32'd5, 32'd7, lat, res, dbz, ill, dl, il, ra, da);
    tests_run++;
    if (lat !== 4) begin
      tests_failed++;
      $display("FAIL add_latency: done in cycle %0d, required 4", lat);
    end
    tests_run++;
    if (res !== 64'd12 || dbz !== 1'b0 || ill !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_result: res=%h dbz=%b ill=%b, required res=c flags 0", res, dbz, ill);
    end
    tests_run++;
    if (ra !== 1'b1 || da !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_ready_after: ready=%b done=%b, required ready=1 done=0", ra, da);
    end
    tests_run++;
    if (alu_y !== 32'd5 || alu_b !== 32'd7 || alu_opcode !== 5'd3) begin
      tests_failed++;
      $display("FAIL add_alu_drive: y=%h b=%h op=%h, required 5 7 3", alu_y, alu_b, alu_opcode);
    end
  endtask

  task automatic test_mul;
    int lat; logic [63:0] res; logic dbz, ill, dl, il, ra, da;
    do_req(5'd15, 32'h0001_0000, 32'h0001_0000, lat, res, dbz, ill, dl, il, ra, da);
    tests_run++;
    if (lat !== MUL_N + 3) begin
      tests_failed++;
      $display("FAIL mul_latency: done in cycle %0d, required %0d", lat, MUL_N + 3);
    end
    tests_run++;
    if (res !== 64'h0000_0001_0000_0000) begin
      tests_failed++;
      $display("FAIL mul_result: res=%h, required 0000000100000000", res);
    end
  endtask

  task automatic test_div_zero;
    int lat; logic [63:0] res; logic dbz, ill, dl, il, ra, da;
    do_req(5'd16, 32'd100, 32'd0, lat, res, dbz, ill, dl, il, ra, da);
    tests_run++;
    if (lat !== 3 || res !== 64'd0 || dbz !== 1'b1 || ill !== 1'b0) begin
      tests_failed++;
      $display("FAIL div_zero: lat=%0d res=%h dbz=%b ill=%b, required lat=3 res=0 dbz=1 ill=0", lat, res, dbz, ill);
    end
    do_req(5'd3, 32'd1, 32'd1, lat, res, dbz, ill, dl, il, ra, da);
    tests_run++;
    if (dl !== 1'b0) begin
      tests_failed++;
      $display("FAIL div_zero_clear: dbz after acceptance=%b, required 0", dl);
    end
    tests_run++;
    if (res !== 64'd2 || dbz !== 1'b0 || lat !== 4) begin
      tests_failed++;
      $display("FAIL add_after_dbz: lat=%0d res=%h dbz=%b, required lat=4 res=2 dbz=0", lat, res, dbz);
    end
  endtask

  task automatic test_illegal;
    int lat; logic [63:0] res; logic dbz, ill, dl, il, ra, da;
    do_req(5'b11111, 32'h1234_5678, 32'h9abc_def0, lat, res, dbz, ill, dl, il, ra, da);
    tests_run++;
    if (lat !== 3 || res !== 64'd0 || ill !== 1'b1 || dbz !== 1'b0) begin
      tests_failed++;
      $display("FAIL illegal_op: lat=%0d res=%h ill=%b dbz=%b, required lat=3 res=0 ill=1 dbz=0", lat, res, ill, dbz);
    end
  endtask

  // start held high from acceptance through DONE: only one done, then re-acceptance after DONE.
  task automatic test_back_to_back;
    int lat;
    bus.start  = 1'b1;
    bus.opcode = 5'd16;
    bus.a      = 32'd100;
    bus.b      = 32'd7;
    @(negedge clk);
    bus.opcode = 5'd3;
    bus.a      = 32'd1;
    bus.b      = 32'd2;
    lat = 1;
    while (!bus.done && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    tests_run++;
    if (lat !== DIV_N + 3 || {bus.result_hi, bus.result_lo} !== {32'd2, 32'd14}) begin
      tests_failed++;
      $display("FAIL ignore_start: lat=%0d res=%h, required lat=%0d res=000000020000000e",
               lat, {bus.result_hi, bus.result_lo}, DIV_N + 3);
    end
    @(negedge clk);
    tests_run++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_cycle_start: ready=%b done=%b after DONE, required ready=1 done=0", bus.ready, bus.done);
    end
    @(negedge clk);
    bus.start = 1'b0;
    tests_run++;
    if (bus.ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL back_to_back_accept: ready=%b, required 0", bus.ready);
    end
    lat = 1;
    while (!bus.done && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    tests_run++;
    if (lat !== 4 || {bus.result_hi, bus.result_lo} !== 64'd3) begin
      tests_failed++;
      $display("FAIL back_to_back_result: lat=%0d res=%h, required lat=4 res=3", lat, {bus.result_hi, bus.result_lo});
    end
    @(negedge clk);
  endtask

  task automatic test_clr_mid;
    int lat; int dones; logic [63:0] res; logic dbz, ill, dl, il, ra, da;
    bus.start  = 1'b1;
    bus.opcode = 5'd16;
    bus.a      = 32'd50;
    bus.b      = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 clr = 1'b0;
    #1;
    tests_run++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL clr_async: ready=%b done=%b, required ready=1 done=0", bus.ready, bus.done);
    end
    tests_run++;
    if ({bus.result_hi, bus.result_lo} !== 64'd0 || alu_y !== 32'd0 || alu_b !== 32'd0) begin
      tests_failed++;
      $display("FAIL clr_values: res=%h alu_y=%h alu_b=%h, required 0", {bus.result_hi, bus.result_lo}, alu_y, alu_b);
    end
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    clr = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    tests_run++;
    if (dones !== 0 || {bus.result_hi, bus.result_lo} !== 64'd0) begin
      tests_failed++;
      $display("FAIL clr_abandon: dones=%0d res=%h, required 0 dones res=0", dones, {bus.result_hi, bus.result_lo});
    end
    do_req(5'd3, 32'd9, 32'd4, lat, res, dbz, ill, dl, il, ra, da);
    tests_run++;
    if (lat !== 4 || res !== 64'd13) begin
      tests_failed++;
      $display("FAIL clr_next_add: lat=%0d res=%h, required lat=4 res=d", lat, res);
    end
  endtask

  task automatic test_random;
    int lat; logic [63:0] res; logic dbz, ill, dl, il, ra, da;
    logic [4:0] op; logic [31:0] av, bv;
    for (int n = 0; n < 40; n++) begin
      av = $urandom;
      bv = $urandom;
      case ($urandom_range(0, 5))
        0: op = 5'd3;
        1: op = 5'd15;
        2: op = 5'd16;
        3: begin op = 5'd16; bv = 32'd0; end
        4: op = 5'($urandom_range(0, 31));
        default: op = 5'($urandom_range(19, 31));
      endcase
      do_req(op, av, bv, lat, res, dbz, ill, dl, il, ra, da);
      tests_run++;
      if (lat !== exp_lat(op, bv)) begin
        tests_failed++;
        $display("FAIL rand_latency[%0d]: op=%0d lat=%0d, required %0d", n, op, lat, exp_lat(op, bv));
      end
      tests_run++;
      if (res !== exp_res(op, av, bv)) begin
        tests_failed++;
        $display("FAIL rand_result[%0d]: op=%0d a=%h b=%h res=%h, required %h", n, op, av, bv, res, exp_res(op, av, bv));
      end
      tests_run++;
      if (dbz !== (op == 5'd16 && bv == 32'd0) || ill !== (op > 5'd18) || dl !== 1'b0 || il !== 1'b0) begin
        tests_failed++;
        $display("FAIL rand_flags[%0d]: op=%0d dbz=%b ill=%b at_load=%b%b, required dbz=%b ill=%b at_load=00",
                 n, op, dbz, ill, dl, il, (op == 5'd16 && bv == 32'd0), (op > 5'd18));
      end
      tests_run++;
      if (ra !== 1'b1 || da !== 1'b0) begin
        tests_failed++;
        $display("FAIL rand_done_pulse[%0d]: ready=%b done=%b after DONE, required 1 0", n, ra, da);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    bus.start    = 1'b0;
    bus.opcode   = 5'd0;
    bus.a        = 32'd0;
    bus.b        = 32'd0;
    clr          = 1'b1;
    test_reset();
    test_add();
    test_mul();
    test_div_zero();
    test_illegal();
    test_back_to_back();
    test_clr_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter MUL_CYCLES, default 4, meaning the EXEC-state dwell in cycles for opcode mul (5'b01111), legal range 1-255.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 8, meaning the EXEC-state dwell in cycles for opcode div (5'b10000), legal range 1-255.
REQ-003 clk  input  1  the single clock; all state changes on rising edge.
REQ-004 clr  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request strobe, sampled on rising clk.
REQ-006 opcode  input  5  ALU opcode of the request.
REQ-007 a  input  32  first operand of the request.
REQ-008 b  input  32  second operand of the request.
REQ-009 ready  output  1  high when a request can be accepted.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 result_lo  output  32  captured ALU result bits [31:0].
REQ-012 result_hi  output  32  captured ALU result bits [63:32].
REQ-013 div_by_zero  output  1  last completed request was div with b == 0.
REQ-014 illegal_op  output  1  last completed request had opcode > 5'b10010.
REQ-015 alu_y  output  32  registered drive to the ALU y operand.
REQ-016 alu_b  output  32  registered drive to the ALU b operand.
REQ-017 alu_opcode  output  5  registered drive to the ALU opcode.
REQ-018 alu_z  input  64  combinational ALU result.

Function
REQ-019 States SHALL be IDLE, LOAD, EXEC, CAPTURE, DONE; ready SHALL be 1 only in IDLE.
REQ-020 A request SHALL be accepted at a rising edge where start=1 and state=IDLE; opcode, a and b SHALL be latched at that edge and state SHALL go to LOAD.
REQ-021 start while not IDLE SHALL be ignored, with no queuing and no effect on the request in flight.
REQ-022 On acceptance, div_by_zero and illegal_op SHALL clear to 0.
REQ-023 LOAD (1 cycle) SHALL drive alu_y=a, alu_b=b and alu_opcode=opcode from the latched values; these outputs SHALL hold until the next acceptance.
REQ-024 EXEC SHALL last N cycles, using a down-counter loaded on entry: N=MUL_CYCLES for mul, N=DIV_CYCLES for div, and N=1 otherwise.
REQ-025 A div request with latched b == 0 SHALL go from LOAD directly to CAPTURE, skipping EXEC.
REQ-026 An opcode > 5'b10010 SHALL go from LOAD directly to CAPTURE, skipping EXEC.
REQ-027 CAPTURE (1 cycle) SHALL register alu_z into {result_hi, result_lo} at its closing edge, except in two cases:
- div by zero: results SHALL be 0 and div_by_zero SHALL be set to 1;
- illegal opcode: results SHALL be 0 and illegal_op SHALL be set to 1.
REQ-028 DONE (1 cycle) SHALL assert done=1, then return to IDLE; done SHALL be 0 in every other state.
REQ-029 For acceptance at edge 0, done SHALL be high during cycle N+3, or cycle 3 for the skip cases, and ready SHALL rise in the following cycle.
REQ-030 result_lo, result_hi and both flags SHALL hold their values until the next CAPTURE or the next acceptance, whichever applies.
REQ-031 start asserted in the DONE cycle SHALL NOT be accepted; the earliest back-to-back acceptance SHALL be in the cycle after DONE.

Reset
REQ-032 clr=0 SHALL immediately, without waiting for clk, force all of the following:
- state IDLE, ready=1, done=0;
- result_lo, result_hi, alu_y and alu_b to 0;
- alu_opcode to 5'b00000;
- div_by_zero=0, illegal_op=0;
- EXEC counter to 0.
REQ-033 clr asserted mid-request SHALL abandon it, with no done pulse and no result update; the first edge after release may accept a new request.

Verification
REQ-034 add: a=5, b=7, opcode=5'b00011, alu_z modelled = a+b -> done in cycle 4, result_lo=12, result_hi=0, flags 0.
REQ-035 mul, default MUL_CYCLES: a=32'h0001_0000, b=32'h0001_0000 -> done in cycle 7, result_hi=1, result_lo=0.
REQ-036 div with b=0, a=100 -> done in cycle 3, results 0, div_by_zero=1; a following add (a=1, b=1) -> div_by_zero cleared on acceptance, result_lo=2.
REQ-037 opcode 5'b11111 -> done in cycle 3, illegal_op=1, results 0; start pulsed during LOAD/EXEC of a div -> ignored, single done.
REQ-038 clr pulsed low during the EXEC of a div -> ready=1 asynchronously, no done, results still 0; next add completes normally.
